// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done operand and result bundle for seq_divider
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring integer divider, signed/unsigned, one op in flight
module seq_divider #(
   parameter int WIDTH          = 32,
   parameter bit SIGNED_SUPPORT = 1'b1
) (
   input  logic         clock,
   input  logic         clear_n,
   seq_divider_if.slave bus
);
   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] p_q, p_d;          // partial remainder (always < divisor, so WIDTH bits suffice)
   logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] m_q, m_d;          // divisor magnitude
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             zero_q, zero_d;    // divisor was zero; q_q then holds the raw dividend
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic             op_signed;
   logic             dd_neg, dv_neg;
   logic [WIDTH-1:0] dd_mag, dv_mag;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   trial;

   // The most-negative value negates to itself, which is its correct unsigned magnitude.
   assign op_signed = SIGNED_SUPPORT && bus.is_signed;
   assign dd_neg    = op_signed && bus.dividend[WIDTH-1];
   assign dv_neg    = op_signed && bus.divisor[WIDTH-1];
   assign dd_mag    = dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
   assign dv_mag    = dv_neg ? (~bus.divisor + 1'b1) : bus.divisor;

   assign p_shift   = {p_q, q_q[WIDTH-1]};
   assign trial     = p_shift - {1'b0, m_q};

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

   // Next-state and datapath update: capture in IDLE, one quotient bit per ITER cycle, sign fix in FIXUP.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      p_d       = p_q;
      q_d       = q_q;
      m_d       = m_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      zero_d    = zero_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               busy_d    = 1'b1;
               neg_quo_d = dd_neg ^ dv_neg;
               neg_rem_d = dd_neg;
               p_d       = '0;
               count_d   = '0;
               m_d       = dv_mag;
               if (bus.divisor == '0) begin
                  zero_d  = 1'b1;
                  q_d     = bus.dividend;
                  state_d = FIXUP;
               end else begin
                  zero_d  = 1'b0;
                  q_d     = dd_mag;
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            if (!trial[WIDTH]) begin
               p_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               p_d = p_shift[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (zero_q) begin
               quo_d = '1;
               rem_d = q_q;
               dbz_d = 1'b1;
            end else begin
               quo_d = neg_quo_q ? (~q_q + 1'b1) : q_q;
               rem_d = neg_rem_q ? (~p_q + 1'b1) : p_q;
               dbz_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any op in flight.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         p_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         p_q       <= p_d;
         q_q       <= q_d;
         m_q       <= m_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         zero_q    <= zero_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with randomized and directed divisions
module tb_seq_divider;
   logic clock;
   logic clear_n;
   int   cyc;
   int   checks;
   int   errors;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          due;
   } exp_t;

   exp_t sb[$];

   seq_divider_if #(.WIDTH(32)) bus ();

   seq_divider #(.WIDTH(32), .SIGNED_SUPPORT(1'b1)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Truncating division computed in 64-bit arithmetic, so most-negative / -1 cannot overflow.
   function automatic exp_t model(input bit sg, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sbv, qq, rr;
      if (b == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         if (sg) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
         end else begin
            sa  = longint'({32'd0, a});
            sbv = longint'({32'd0, b});
         end
         qq    = sa / sbv;
         rr    = sa % sbv;
         e.q   = qq[31:0];
         e.r   = rr[31:0];
         e.dbz = 1'b0;
      end
      e.due = 0;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t e;
      if (clear_n === 1'b1 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("quotient", bus.quotient, e.q);
            chk("remainder", bus.remainder, e.r);
            chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
            chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
            chk("latency_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   // Issue one op at the next edge, optionally pulse start again at E0+poke, then wait for done.
   // Returns at the negedge where done is seen, so a following call is accepted in the done cycle.
   task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int poke);
      exp_t e;
      int   lat;
      bit   got;
      bus.start     = 1'b1;
      bus.is_signed = sg;
      bus.dividend  = a;
      bus.divisor   = b;
      @(posedge clock);
      #1;
      bus.start     = 1'b0;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = ~sg;
      e     = model(sg, a, b);
      lat   = e.dbz ? 1 : 33;
      e.due = cyc + lat;
      sb.push_back(e);
      chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      got = 1'b0;
      for (int n = 1; n <= lat + 4; n++) begin
         @(negedge clock);
         if (bus.done === 1'b1) begin
            got = 1'b1;
            break;
         end
         chk("busy_in_flight", {31'd0, bus.busy}, 32'd1);
         if (n == poke) begin
            bus.start    = 1'b1;
            bus.dividend = $urandom;
            bus.divisor  = $urandom_range(1, 50);
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 expected=1 at cycle %0d", cyc);
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, b;
      bit          sg;
      int          sel;
      checks        = 0;
      errors        = 0;
      clear_n       = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      #12;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_quotient", bus.quotient, 32'd0);
      chk("reset_remainder", bus.remainder, 32'd0);
      chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      #5;
      clear_n = 1'b1;
      @(negedge clock);

      run_op(1'b0, 32'd100, 32'd7, 5);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(1'b0, 32'd5, 32'd0, 0);
      run_op(1'b0, 32'd9, 32'd3, 0);
      run_op(1'b1, 32'd5, 32'd0, 0);
      run_op(1'b1, 32'hFFFF_FFF6, 32'd0, 0);
      run_op(1'b0, 32'd3, 32'd9, 0);

      for (int i = 0; i < 40; i++) begin
         sg  = 1'($urandom_range(0, 1));
         a   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3:       b = 32'd0 - 32'($urandom_range(1, 9));
            4: begin a = a >> $urandom_range(0, 31); b = $urandom >> $urandom_range(0, 31); end
            default: b = $urandom;
         endcase
         run_op(sg, a, b, $urandom_range(0, 3) == 0 ? $urandom_range(1, 30) : 0);
      end

      run_op(1'b0, 32'd1000, 32'd7, 0);

      // Reset mid-operation: outputs clear without waiting for an edge and the op never completes.
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd100;
      bus.divisor   = 32'd7;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      clear_n = 1'b0;
      #1;
      chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
      chk("midreset_done", {31'd0, bus.done}, 32'd0);
      chk("midreset_quotient", bus.quotient, 32'd0);
      chk("midreset_remainder", bus.remainder, 32'd0);
      chk("midreset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      repeat (2) @(posedge clock);
      #3;
      clear_n = 1'b1;
      @(posedge clock);
      #1;
      chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
      repeat (40) @(negedge clock);

      run_op(1'b1, 32'd100, 32'd7, 0);
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0);

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
